// File: rtl/ex_stage_pipe_if.sv
// EX->MEM stage bus: upstream beat, downstream entry, exception inputs and strobes.
// Latency: none, this is wiring only.
// Backpressure: in_ready/out_ready valid-ready pair; slave is the stage, master the neighbours.
interface ex_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int REG_W  = 5,
  parameter int OP_W   = 2,
  parameter int EXP_W  = 3,
  parameter int SIDE_W = 3
);
  // control and exception sideband
  logic              flush;
  logic              int_detect;
  logic [EXP_W-1:0]  int_type;
  logic              alu_of;

  // upstream beat
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic              in_br_flag;
  logic [OP_W-1:0]   in_mem_op;
  logic [OP_W-1:0]   in_ctrl_op;
  logic [REG_W-1:0]  in_dst_addr;
  logic              in_gpr_we_;
  logic [EXP_W-1:0]  in_exp_code;
  logic [DATA_W-1:0] in_alu_out;
  logic [DATA_W-1:0] in_wr_data;
  logic [SIDE_W-1:0] in_cp_sel;

  // downstream entry
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic              out_br_flag;
  logic [OP_W-1:0]   out_mem_op;
  logic [OP_W-1:0]   out_ctrl_op;
  logic [REG_W-1:0]  out_dst_addr;
  logic              out_gpr_we_;
  logic [EXP_W-1:0]  out_exp_code;
  logic [DATA_W-1:0] out_alu_out;
  logic [DATA_W-1:0] out_wr_data;
  logic [SIDE_W-1:0] out_cp_sel;

  // delayed coprocessor select pulses
  logic [SIDE_W-1:0] cp_strobe;

  modport slave (
    input  flush, int_detect, int_type, alu_of,
    input  in_valid, in_pc, in_br_flag, in_mem_op, in_ctrl_op, in_dst_addr,
           in_gpr_we_, in_exp_code, in_alu_out, in_wr_data, in_cp_sel,
    output in_ready,
    output out_valid, out_pc, out_br_flag, out_mem_op, out_ctrl_op, out_dst_addr,
           out_gpr_we_, out_exp_code, out_alu_out, out_wr_data, out_cp_sel,
    input  out_ready,
    output cp_strobe
  );

  modport master (
    output flush, int_detect, int_type, alu_of,
    output in_valid, in_pc, in_br_flag, in_mem_op, in_ctrl_op, in_dst_addr,
           in_gpr_we_, in_exp_code, in_alu_out, in_wr_data, in_cp_sel,
    input  in_ready,
    input  out_valid, out_pc, out_br_flag, out_mem_op, out_ctrl_op, out_dst_addr,
           out_gpr_we_, out_exp_code, out_alu_out, out_wr_data, out_cp_sel,
    output out_ready,
    input  cp_strobe
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// EX->MEM pipeline register with 2-entry skid, exception substitution and delayed cp strobes.
// Latency: 1 cycle accept->out_valid; cp_strobe SIDE_DLY cycles after the entry drains.
// Backpressure: in_ready is registered (!skid_valid), so the skid slot absorbs the beat in flight.
module ex_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 30,
  parameter int REG_W    = 5,
  parameter int OP_W     = 2,
  parameter int EXP_W    = 3,
  parameter int EXP_OVF  = 3,
  parameter int SIDE_W   = 3,
  parameter int SIDE_DLY = 1
) (
  input logic            clk,
  input logic            reset,
  ex_stage_pipe_if.slave bus
);

  // One pipeline entry; the interface widths must match the parameters above.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              br_flag;
    logic [OP_W-1:0]   mem_op;
    logic [OP_W-1:0]   ctrl_op;
    logic [REG_W-1:0]  dst_addr;
    logic              gpr_we_;
    logic [EXP_W-1:0]  exp_code;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wr_data;
    logic [SIDE_W-1:0] cp_sel;
  } ent_t;

  ent_t bubble;
  ent_t in_ent;
  ent_t cap_ent;
  ent_t main_q;
  ent_t skid_q;
  logic main_valid;
  logic skid_valid;
  logic accept;
  logic drain;
  logic [SIDE_W-1:0] drain_sel;

  // Bubble payload: a harmless entry that never writes the register file.
  always_comb begin
    bubble         = '0;
    bubble.gpr_we_ = 1'b1;
  end

  // Gather the upstream beat into one entry.
  always_comb begin
    in_ent          = '0;
    in_ent.pc       = bus.in_pc;
    in_ent.br_flag  = bus.in_br_flag;
    in_ent.mem_op   = bus.in_mem_op;
    in_ent.ctrl_op  = bus.in_ctrl_op;
    in_ent.dst_addr = bus.in_dst_addr;
    in_ent.gpr_we_  = bus.in_gpr_we_;
    in_ent.exp_code = bus.in_exp_code;
    in_ent.alu_out  = bus.in_alu_out;
    in_ent.wr_data  = bus.in_wr_data;
    in_ent.cp_sel   = bus.in_cp_sel;
  end

  // Exception substitution: interrupt beats overflow; pc/br_flag survive for the handler.
  always_comb begin
    cap_ent = in_ent;
    if (bus.int_detect || bus.alu_of) begin
      cap_ent.mem_op   = '0;
      cap_ent.ctrl_op  = '0;
      cap_ent.dst_addr = '0;
      cap_ent.gpr_we_  = 1'b1;
      cap_ent.alu_out  = '0;
      cap_ent.wr_data  = '0;
      cap_ent.cp_sel   = '0;
      cap_ent.exp_code = bus.int_detect ? bus.int_type : EXP_W'(EXP_OVF);
    end
  end

  // in_ready only depends on registered skid state (plus reset), never on out_ready.
  assign bus.in_ready  = !skid_valid && !reset;
  assign bus.out_valid = main_valid;
  assign accept        = bus.in_valid && bus.in_ready;
  assign drain         = main_valid && bus.out_ready;

  // Main/skid storage: skid refills main first, so order stays FIFO.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= bubble;
      skid_q     <= bubble;
    end else if (drain) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= cap_ent;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (!main_valid) begin
      if (accept) begin
        main_q     <= cap_ent;
        main_valid <= 1'b1;
      end
    end else if (accept) begin
      skid_q     <= cap_ent;
      skid_valid <= 1'b1;
    end
  end

  assign bus.out_pc       = main_q.pc;
  assign bus.out_br_flag  = main_q.br_flag;
  assign bus.out_mem_op   = main_q.mem_op;
  assign bus.out_ctrl_op  = main_q.ctrl_op;
  assign bus.out_dst_addr = main_q.dst_addr;
  assign bus.out_gpr_we_  = main_q.gpr_we_;
  assign bus.out_exp_code = main_q.exp_code;
  assign bus.out_alu_out  = main_q.alu_out;
  assign bus.out_wr_data  = main_q.wr_data;
  assign bus.out_cp_sel   = main_q.cp_sel;

  // Selects of the entry leaving this cycle.
  assign drain_sel = drain ? main_q.cp_sel : '0;

  if (SIDE_DLY == 0) begin : g_strobe_comb
    // Zero delay: pulse in the drain cycle itself, suppressed when the drain is flushed.
    assign bus.cp_strobe = (reset || bus.flush) ? '0 : drain_sel;
  end else begin : g_strobe_line
    logic [SIDE_W-1:0] stage [SIDE_DLY];

    // Delay line: flush/reset wipe every pending pulse, including the one draining now.
    always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
        for (int k = 0; k < SIDE_DLY; k++) stage[k] <= '0;
      end else begin
        stage[0] <= drain_sel;
        for (int k = 1; k < SIDE_DLY; k++) stage[k] <= stage[k-1];
      end
    end

    assign bus.cp_strobe = reset ? '0 : stage[SIDE_DLY-1];
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: two instances (strobe delay 1 and 0) share one stimulus.
// Latency: checks sampled 2 time units after each rising edge, inputs driven 1 unit after.
// Backpressure: out_ready driven per vector to exercise skid fill and drain.
module tb_ex_stage_pipe;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  ex_stage_pipe_if bus1 ();
  ex_stage_pipe_if bus0 ();

  ex_stage_pipe #(.SIDE_DLY(1)) u_dly1 (.clk(clk), .reset(reset), .bus(bus1));
  ex_stage_pipe #(.SIDE_DLY(0)) u_dly0 (.clk(clk), .reset(reset), .bus(bus0));

  // second instance sees exactly the same inputs
  assign bus0.flush       = bus1.flush;
  assign bus0.int_detect  = bus1.int_detect;
  assign bus0.int_type    = bus1.int_type;
  assign bus0.alu_of      = bus1.alu_of;
  assign bus0.in_valid    = bus1.in_valid;
  assign bus0.in_pc       = bus1.in_pc;
  assign bus0.in_br_flag  = bus1.in_br_flag;
  assign bus0.in_mem_op   = bus1.in_mem_op;
  assign bus0.in_ctrl_op  = bus1.in_ctrl_op;
  assign bus0.in_dst_addr = bus1.in_dst_addr;
  assign bus0.in_gpr_we_  = bus1.in_gpr_we_;
  assign bus0.in_exp_code = bus1.in_exp_code;
  assign bus0.in_alu_out  = bus1.in_alu_out;
  assign bus0.in_wr_data  = bus1.in_wr_data;
  assign bus0.in_cp_sel   = bus1.in_cp_sel;
  assign bus0.out_ready   = bus1.out_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_in();
    bus1.flush       = 1'b0;
    bus1.int_detect  = 1'b0;
    bus1.int_type    = '0;
    bus1.alu_of      = 1'b0;
    bus1.in_valid    = 1'b0;
    bus1.in_pc       = '0;
    bus1.in_br_flag  = 1'b0;
    bus1.in_mem_op   = '0;
    bus1.in_ctrl_op  = '0;
    bus1.in_dst_addr = '0;
    bus1.in_gpr_we_  = 1'b1;
    bus1.in_exp_code = '0;
    bus1.in_alu_out  = '0;
    bus1.in_wr_data  = '0;
    bus1.in_cp_sel   = '0;
  endtask

  task automatic beat(input logic [29:0] pc);
    idle_in();
    bus1.in_valid = 1'b1;
    bus1.in_pc    = pc;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    bus1.out_ready = 1'b0;
    tick();
    tick();
    settle();
    check_eq("rst_in_ready", bus1.in_ready, 0);
    check_eq("rst_out_valid", bus1.out_valid, 0);
    check_eq("rst_gpr_we", bus1.out_gpr_we_, 1);
    check_eq("rst_exp", bus1.out_exp_code, 0);
    check_eq("rst_strobe1", bus1.cp_strobe, 0);
    check_eq("rst_strobe0", bus0.cp_strobe, 0);
    reset = 1'b0;

    // streaming at full rate
    for (int i = 1; i <= 6; i++) begin
      beat(30'(i));
      bus1.out_ready = 1'b1;
      settle();
      check_eq("strm_in_ready", bus1.in_ready, 1);
      if (i > 1) begin
        check_eq("strm_valid", bus1.out_valid, 1);
        check_eq("strm_pc", bus1.out_pc, 64'(i - 1));
      end
      tick();
    end
    idle_in();
    settle();
    check_eq("strm_last_valid", bus1.out_valid, 1);
    check_eq("strm_last_pc", bus1.out_pc, 6);
    tick();
    settle();
    check_eq("strm_empty", bus1.out_valid, 0);
    bus1.out_ready = 1'b0;

    // skid fill and drain
    beat(30'd10);
    settle();
    check_eq("skid_rdy0", bus1.in_ready, 1);
    tick();
    beat(30'd11);
    settle();
    check_eq("skid_rdy1", bus1.in_ready, 1);
    check_eq("skid_main10", bus1.out_pc, 10);
    tick();
    beat(30'd12);
    settle();
    check_eq("skid_full_rdy", bus1.in_ready, 0);
    check_eq("skid_hold10", bus1.out_pc, 10);
    tick();
    bus1.out_ready = 1'b1;
    settle();
    check_eq("skid_rdy_still0", bus1.in_ready, 0);
    check_eq("skid_out10", bus1.out_pc, 10);
    tick();
    settle();
    check_eq("skid_rdy_back", bus1.in_ready, 1);
    check_eq("skid_out11", bus1.out_pc, 11);
    tick();
    idle_in();
    settle();
    check_eq("skid_valid12", bus1.out_valid, 1);
    check_eq("skid_out12", bus1.out_pc, 12);
    tick();
    bus1.out_ready = 1'b0;
    settle();
    check_eq("skid_empty", bus1.out_valid, 0);

    // overflow substitution
    beat(30'h20);
    bus1.in_br_flag  = 1'b1;
    bus1.in_dst_addr = 5'd5;
    bus1.in_gpr_we_  = 1'b0;
    bus1.in_mem_op   = 2'd2;
    bus1.in_ctrl_op  = 2'd1;
    bus1.in_alu_out  = 32'hdead;
    bus1.in_wr_data  = 32'hbeef;
    bus1.in_cp_sel   = 3'b111;
    bus1.alu_of      = 1'b1;
    settle();
    tick();
    idle_in();
    settle();
    check_eq("ovf_exp", bus1.out_exp_code, 3);
    check_eq("ovf_we", bus1.out_gpr_we_, 1);
    check_eq("ovf_dst", bus1.out_dst_addr, 0);
    check_eq("ovf_pc", bus1.out_pc, 64'h20);
    check_eq("ovf_br", bus1.out_br_flag, 1);
    check_eq("ovf_alu", bus1.out_alu_out, 0);
    check_eq("ovf_wr", bus1.out_wr_data, 0);
    check_eq("ovf_mem", bus1.out_mem_op, 0);
    check_eq("ovf_cp", bus1.out_cp_sel, 0);

    // interrupt wins over overflow; previous entry drains with no strobe
    beat(30'h21);
    bus1.in_dst_addr = 5'd5;
    bus1.in_gpr_we_  = 1'b0;
    bus1.in_alu_out  = 32'hdead;
    bus1.alu_of      = 1'b1;
    bus1.int_detect  = 1'b1;
    bus1.int_type    = 3'd2;
    bus1.out_ready   = 1'b1;
    settle();
    check_eq("ovf_drain_strobe0", bus0.cp_strobe, 0);
    tick();
    idle_in();
    bus1.int_detect = 1'b1;
    bus1.alu_of     = 1'b1;
    bus1.out_ready  = 1'b0;
    settle();
    check_eq("int_exp", bus1.out_exp_code, 2);
    check_eq("int_pc", bus1.out_pc, 64'h21);
    check_eq("int_dst", bus1.out_dst_addr, 0);
    tick();

    // clean beat passes every field unchanged
    beat(30'h22);
    bus1.in_dst_addr = 5'd9;
    bus1.in_gpr_we_  = 1'b0;
    bus1.in_exp_code = 3'd1;
    bus1.in_alu_out  = 32'h1234_5678;
    bus1.in_wr_data  = 32'hcafe;
    bus1.in_mem_op   = 2'd1;
    bus1.in_ctrl_op  = 2'd2;
    bus1.in_cp_sel   = 3'b101;
    bus1.out_ready   = 1'b1;
    settle();
    tick();
    idle_in();
    bus1.out_ready = 1'b0;
    settle();
    check_eq("pass_pc", bus1.out_pc, 64'h22);
    check_eq("pass_dst", bus1.out_dst_addr, 9);
    check_eq("pass_we", bus1.out_gpr_we_, 0);
    check_eq("pass_exp", bus1.out_exp_code, 1);
    check_eq("pass_alu", bus1.out_alu_out, 64'h1234_5678);
    check_eq("pass_wr", bus1.out_wr_data, 64'hcafe);
    check_eq("pass_mem", bus1.out_mem_op, 1);
    check_eq("pass_ctrl", bus1.out_ctrl_op, 2);
    check_eq("pass_cp", bus1.out_cp_sel, 5);
    tick();
    bus1.out_ready = 1'b1;
    settle();
    check_eq("pass_strobe0", bus0.cp_strobe, 5);
    tick();
    bus1.out_ready = 1'b0;
    settle();
    check_eq("pass_strobe1", bus1.cp_strobe, 5);
    tick();

    // strobe timing: drain at T
    beat(30'h28);
    bus1.in_cp_sel = 3'b010;
    settle();
    tick();
    idle_in();
    settle();
    check_eq("stb_pre1", bus1.cp_strobe, 0);
    bus1.out_ready = 1'b1;
    settle();
    check_eq("stb_T_dly0", bus0.cp_strobe, 3'b010);
    check_eq("stb_T_dly1", bus1.cp_strobe, 0);
    tick();
    bus1.out_ready = 1'b0;
    settle();
    check_eq("stb_T1_dly1", bus1.cp_strobe, 3'b010);
    check_eq("stb_T1_dly0", bus0.cp_strobe, 0);
    tick();
    settle();
    check_eq("stb_T2_dly1", bus1.cp_strobe, 0);

    // flush with main+skid full and a strobe-carrying drain
    beat(30'h30);
    bus1.in_cp_sel = 3'b100;
    settle();
    tick();
    beat(30'h31);
    bus1.in_cp_sel = 3'b001;
    settle();
    tick();
    idle_in();
    settle();
    check_eq("fl_full_rdy", bus1.in_ready, 0);
    check_eq("fl_full_pc", bus1.out_pc, 64'h30);
    beat(30'h32);
    bus1.out_ready = 1'b1;
    bus1.flush     = 1'b1;
    settle();
    check_eq("fl_strobe0", bus0.cp_strobe, 0);
    tick();
    idle_in();
    bus1.out_ready = 1'b0;
    settle();
    check_eq("fl_valid", bus1.out_valid, 0);
    check_eq("fl_rdy", bus1.in_ready, 1);
    check_eq("fl_we", bus1.out_gpr_we_, 1);
    check_eq("fl_exp", bus1.out_exp_code, 0);
    check_eq("fl_pc", bus1.out_pc, 0);
    check_eq("fl_strobe1", bus1.cp_strobe, 0);
    tick();
    settle();
    check_eq("fl_strobe1_late", bus1.cp_strobe, 0);
    check_eq("fl_dropped", bus1.out_valid, 0);

    // reset mid-transfer with skid full
    beat(30'h40);
    bus1.in_cp_sel = 3'b010;
    settle();
    tick();
    beat(30'h41);
    settle();
    tick();
    beat(30'h42);
    reset = 1'b1;
    bus1.out_ready = 1'b1;
    settle();
    check_eq("mr_rdy0", bus1.in_ready, 0);
    check_eq("mr_strobe1", bus1.cp_strobe, 0);
    check_eq("mr_strobe0", bus0.cp_strobe, 0);
    tick();
    bus1.out_ready = 1'b0;
    settle();
    check_eq("mr_rdy1", bus1.in_ready, 0);
    check_eq("mr_valid", bus1.out_valid, 0);
    tick();
    bus1.out_ready = 1'b1;
    tick();
    reset = 1'b0;
    idle_in();
    bus1.out_ready = 1'b0;
    settle();
    check_eq("mr_post_valid", bus1.out_valid, 0);
    check_eq("mr_post_rdy", bus1.in_ready, 1);
    check_eq("mr_post_stb1", bus1.cp_strobe, 0);
    check_eq("mr_post_stb0", bus0.cp_strobe, 0);
    beat(30'h50);
    bus1.in_dst_addr = 5'd7;
    bus1.in_gpr_we_  = 1'b0;
    bus1.in_alu_out  = 32'h1234;
    settle();
    tick();
    idle_in();
    settle();
    check_eq("mr_first_valid", bus1.out_valid, 1);
    check_eq("mr_first_pc", bus1.out_pc, 64'h50);
    check_eq("mr_first_dst", bus1.out_dst_addr, 7);
    check_eq("mr_first_we", bus1.out_gpr_we_, 0);
    check_eq("mr_first_alu", bus1.out_alu_out, 64'h1234);
    check_eq("mr_first_exp", bus1.out_exp_code, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised EX→MEM pipeline stage register; successor to the fixed stall/flush EX register.
- Replaces global stall with a valid/ready handshake. A 2-entry skid buffer gives full throughput and a registered in_ready.
- Applies interrupt/overflow exception substitution at capture.
- Issues coprocessor select strobes delayed by a configurable number of cycles after the entry leaves the stage.

Parameters:
- DATA_W, 32, data/ALU result width
- ADDR_W, 30, word PC width
- REG_W, 5, GPR address width
- OP_W, 2, width of mem_op and of ctrl_op (NOP = 0)
- EXP_W, 3, exception code width (NOEXP = 0)
- EXP_OVF, 3, overflow exception code
- SIDE_W, 3, coprocessor select strobe count
- SIDE_DLY, 1, strobe delay in cycles after output transfer, legal 0..3

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  kill all held entries and pending strobes
- int_detect  in  1  interrupt pending, sampled with the input beat
- int_type  in  EXP_W  interrupt exception code
- alu_of  in  1  ALU overflow for the input beat
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept
- in_pc  in  ADDR_W  PC
- in_br_flag  in  1  branch-delay flag
- in_mem_op  in  OP_W  memory op
- in_ctrl_op  in  OP_W  control op
- in_dst_addr  in  REG_W  destination GPR
- in_gpr_we_  in  1  GPR write enable, active-low
- in_exp_code  in  EXP_W  upstream exception
- in_alu_out  in  DATA_W  ALU result
- in_wr_data  in  DATA_W  store / coprocessor write data
- in_cp_sel  in  SIDE_W  coprocessor selects
- out_valid  out  1  entry valid
- out_ready  in  1  downstream accepts
- out_pc, out_br_flag, out_mem_op, out_ctrl_op, out_dst_addr, out_gpr_we_, out_exp_code, out_alu_out, out_wr_data, out_cp_sel  out  (widths as in_*)  held entry payload
- cp_strobe  out  SIDE_W  delayed one-cycle coprocessor select pulses

Behaviour:
- Storage: main register (drives out_*) plus one skid register, each with a valid bit.
- out_valid = main_valid.
- in_ready = !skid_valid && !reset; it is a registered term, with no combinational path from out_ready.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Accept when main is empty or drained this cycle: load main. If skid is also valid in that cycle, skid moves to main first; that case cannot coincide with accept because in_ready=0.
- Accept when main is full and not draining: load skid; in_ready falls next cycle.
- Drain with skid valid: main ← skid, skid cleared, in_ready rises next cycle.
- Drain with no accept and skid empty: main_valid ← 0; payload holds its last value.
- Ordering is strictly FIFO. Back-to-back throughput is 1 beat/cycle; latency is 1 cycle from accept to out_valid.
- Capture transform when int_detect=1 (priority over alu_of):
  - pc and br_flag pass through; exp_code ← int_type.
  - mem_op, ctrl_op, dst_addr, alu_out, wr_data, cp_sel ← 0; gpr_we_ ← 1.
- Capture transform when alu_of=1 and int_detect=0: same as above with exp_code ← EXP_OVF.
- Otherwise all fields pass unchanged.
- int_detect and alu_of are ignored on cycles with no accept.
- Strobe delay line, SIDE_DLY ≥ 1:
  - Stage0 ← (Drain ? out_cp_sel : 0) each cycle; stage k ← stage k-1.
  - cp_strobe = stage[SIDE_DLY-1].
- Strobe path, SIDE_DLY = 0: cp_strobe = Drain ? out_cp_sel : 0 (combinational).
- flush (sync):
  - Both valids ← 0, delay line ← 0.
  - Main payload ← bubble pattern: all zero except gpr_we_=1.
  - Any input offered that cycle is dropped; in_ready=1 next cycle.
  - A Drain in the flush cycle still counts downstream, but its strobe is discarded.
- Reset (sync, overrides flush): same state as flush, cp_strobe=0, in_ready=0 while reset is high.
- Reset mid-transfer loses all entries without a partial update.

Test Plan:
- Reset then in_valid=1 every cycle with pc=1,2,3…, out_ready=1 → out_valid from cycle 1, out_pc=1,2,3… one cycle later, in_ready never drops.
- Send pc=10,11,12 with out_ready=0 → pc=10 in main, pc=11 in skid, in_ready=0 and pc=12 held upstream; raise out_ready → outputs 10,11,12 on consecutive cycles, no loss or duplication.
- in_dst_addr=5, gpr_we_=0, alu_of=1 → out_exp_code=3, out_gpr_we_=1, out_dst_addr=0; repeat with int_detect=1, int_type=2, alu_of=1 → out_exp_code=2.
- in_cp_sel=3'b010 drained at cycle T, SIDE_DLY=1 → cp_strobe=3'b010 only at T+1; rerun with SIDE_DLY=0 → pulse at T.
- Main and skid full, cp pulse pending, flush=1 → next cycle out_valid=0, in_ready=1, out_gpr_we_=1, out_exp_code=0, no cp_strobe.
- Assert reset while skid full and out_ready toggling → in_ready=0 during reset, all valids and strobes 0 afterwards, first post-reset beat emerges intact.
